// File: rtl/vrb_arbiter_if.sv
// Command/response bundle for one VRB memory port. Masters use `master`,
// the arbiter faces each master with `slave` and drives memory through `mem_master`.
interface vrb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cmd_valid;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            cmd_ready;
    logic            rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    // The shared memory accepts every command, so this side carries no ready.
    modport mem_master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
        input  rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/vrb_arbiter.sv
// Shares one VRB memory port between EXT, IFU and LSU: EXT has priority,
// IFU/LSU alternate, one transaction in flight, missing responses time out.
module vrb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vrb_arbiter_if.slave      ext_if,
    vrb_arbiter_if.slave      ifu_if,
    vrb_arbiter_if.slave      lsu_if,
    vrb_arbiter_if.mem_master mem_if,
    output logic              o_busy
);
    localparam int MW = DW / 8;
    localparam int M_EXT = 0;
    localparam int M_IFU = 1;
    localparam int M_LSU = 2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t     state_q;
    logic [2:0] grant_q;
    logic       rr_last_q;
    logic [7:0] tmo_cnt_q;

    logic [2:0]    req;
    logic [2:0]    win;
    logic [AW-1:0] addr_arr  [3];
    logic          read_arr  [3];
    logic [DW-1:0] wdata_arr [3];
    logic [MW-1:0] wmask_arr [3];
    logic [AW-1:0] addr_m    [3];
    logic          read_m    [3];
    logic [DW-1:0] wdata_m   [3];
    logic [MW-1:0] wmask_m   [3];

    logic          in_wait;
    logic          rsp_fire;
    logic          tmo_fire;
    logic          done;
    logic          rsp_err_mux;
    logic [DW-1:0] rsp_rdata_mux;
    logic [2:0]    rsp_v_vec;

    assign req = {lsu_if.cmd_valid, ifu_if.cmd_valid, ext_if.cmd_valid};

    assign addr_arr[M_EXT]  = ext_if.cmd_addr;
    assign addr_arr[M_IFU]  = ifu_if.cmd_addr;
    assign addr_arr[M_LSU]  = lsu_if.cmd_addr;
    assign read_arr[M_EXT]  = ext_if.cmd_read;
    assign read_arr[M_IFU]  = ifu_if.cmd_read;
    assign read_arr[M_LSU]  = lsu_if.cmd_read;
    assign wdata_arr[M_EXT] = ext_if.cmd_wdata;
    assign wdata_arr[M_IFU] = ifu_if.cmd_wdata;
    assign wdata_arr[M_LSU] = lsu_if.cmd_wdata;
    assign wmask_arr[M_EXT] = ext_if.cmd_wmask;
    assign wmask_arr[M_IFU] = ifu_if.cmd_wmask;
    assign wmask_arr[M_LSU] = lsu_if.cmd_wmask;

    // rr_last_q=1 means LSU was served last, so IFU takes the next tie.
    always_comb begin
        win = 3'b000;
        if (state_q == ST_IDLE) begin
            if (req[M_EXT]) begin
                win[M_EXT] = 1'b1;
            end else if (req[M_IFU] && (!req[M_LSU] || rr_last_q)) begin
                win[M_IFU] = 1'b1;
            end else if (req[M_LSU]) begin
                win[M_LSU] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mask
            assign addr_m[gi]  = addr_arr[gi]  & {AW{win[gi]}};
            assign read_m[gi]  = read_arr[gi]  & win[gi];
            assign wdata_m[gi] = wdata_arr[gi] & {DW{win[gi]}};
            assign wmask_m[gi] = wmask_arr[gi] & {MW{win[gi]}};
        end
    endgenerate

    // win is one-hot or zero, so OR-ing the masked payloads is the mux.
    assign mem_if.cmd_valid = |win;
    assign mem_if.cmd_addr  = addr_m[0]  | addr_m[1]  | addr_m[2];
    assign mem_if.cmd_read  = read_m[0]  | read_m[1]  | read_m[2];
    assign mem_if.cmd_wdata = wdata_m[0] | wdata_m[1] | wdata_m[2];
    assign mem_if.cmd_wmask = wmask_m[0] | wmask_m[1] | wmask_m[2];

    assign ext_if.cmd_ready = win[M_EXT];
    assign ifu_if.cmd_ready = win[M_IFU];
    assign lsu_if.cmd_ready = win[M_LSU];

    assign in_wait       = (state_q == ST_WAIT);
    assign rsp_fire      = in_wait && mem_if.rsp_valid;
    assign tmo_fire      = in_wait && !mem_if.rsp_valid && (tmo_cnt_q == TMO_LAST);
    assign done          = rsp_fire || tmo_fire;
    assign rsp_err_mux   = rsp_fire ? mem_if.rsp_err : 1'b1;
    assign rsp_rdata_mux = rsp_fire ? mem_if.rsp_rdata : '0;
    assign rsp_v_vec     = grant_q & {3{done}};

    assign ext_if.rsp_valid = rsp_v_vec[M_EXT];
    assign ifu_if.rsp_valid = rsp_v_vec[M_IFU];
    assign lsu_if.rsp_valid = rsp_v_vec[M_LSU];
    assign ext_if.rsp_err   = rsp_v_vec[M_EXT] & rsp_err_mux;
    assign ifu_if.rsp_err   = rsp_v_vec[M_IFU] & rsp_err_mux;
    assign lsu_if.rsp_err   = rsp_v_vec[M_LSU] & rsp_err_mux;
    assign ext_if.rsp_rdata = {DW{rsp_v_vec[M_EXT]}} & rsp_rdata_mux;
    assign ifu_if.rsp_rdata = {DW{rsp_v_vec[M_IFU]}} & rsp_rdata_mux;
    assign lsu_if.rsp_rdata = {DW{rsp_v_vec[M_LSU]}} & rsp_rdata_mux;

    assign o_busy = in_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            rr_last_q <= 1'b1;
            tmo_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|win) begin
                        state_q   <= ST_WAIT;
                        grant_q   <= win;
                        tmo_cnt_q <= 8'd0;
                        if (win[M_IFU]) begin
                            rr_last_q <= 1'b0;
                        end else if (win[M_LSU]) begin
                            rr_last_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (done) begin
                        state_q <= ST_IDLE;
                        grant_q <= 3'b000;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 3'b000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vrb_arbiter.sv
// Self-checking bench for vrb_arbiter: directed scenarios then random traffic
// checked against a transaction-level model of priority, alternation and timeout.
module tb_vrb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TMO = 16;
    localparam int EXT = 0;
    localparam int IFU = 1;
    localparam int LSU = 2;

    logic clk;
    logic rst_n;
    logic busy;

    vrb_arbiter_if #(.AW(AW), .DW(DW)) ext_bus ();
    vrb_arbiter_if #(.AW(AW), .DW(DW)) ifu_bus ();
    vrb_arbiter_if #(.AW(AW), .DW(DW)) lsu_bus ();
    vrb_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

    vrb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ext_if (ext_bus),
        .ifu_if (ifu_bus),
        .lsu_if (lsu_bus),
        .mem_if (mem_bus),
        .o_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model state: pending requests per master and who among IFU/LSU was served last.
    logic        pend [3];
    logic [31:0] p_addr [3];
    logic        p_read [3];
    logic [31:0] p_wdata [3];
    logic [3:0]  p_wmask [3];
    int          last_srv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ready_vec();
        return {lsu_bus.cmd_ready, ifu_bus.cmd_ready, ext_bus.cmd_ready};
    endfunction

    function automatic logic [2:0] rspv_vec();
        return {lsu_bus.rsp_valid, ifu_bus.rsp_valid, ext_bus.rsp_valid};
    endfunction

    function automatic logic [2:0] err_vec();
        return {lsu_bus.rsp_err, ifu_bus.rsp_err, ext_bus.rsp_err};
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        if (m == EXT) return ext_bus.rsp_rdata;
        if (m == IFU) return ifu_bus.rsp_rdata;
        return lsu_bus.rsp_rdata;
    endfunction

    function automatic int exp_winner();
        if (pend[EXT]) return EXT;
        if (pend[IFU] && pend[LSU]) return (last_srv == IFU) ? LSU : IFU;
        if (pend[IFU]) return IFU;
        if (pend[LSU]) return LSU;
        return -1;
    endfunction

    task automatic apply_masters();
        ext_bus.cmd_valid = pend[EXT]; ext_bus.cmd_addr = p_addr[EXT];
        ext_bus.cmd_read  = p_read[EXT]; ext_bus.cmd_wdata = p_wdata[EXT];
        ext_bus.cmd_wmask = p_wmask[EXT];
        ifu_bus.cmd_valid = pend[IFU]; ifu_bus.cmd_addr = p_addr[IFU];
        ifu_bus.cmd_read  = p_read[IFU]; ifu_bus.cmd_wdata = p_wdata[IFU];
        ifu_bus.cmd_wmask = p_wmask[IFU];
        lsu_bus.cmd_valid = pend[LSU]; lsu_bus.cmd_addr = p_addr[LSU];
        lsu_bus.cmd_read  = p_read[LSU]; lsu_bus.cmd_wdata = p_wdata[LSU];
        lsu_bus.cmd_wmask = p_wmask[LSU];
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
        pend[m] = 1'b1; p_addr[m] = a; p_read[m] = rd; p_wdata[m] = wd; p_wmask[m] = wm;
    endtask

    task automatic set_mem_rsp(input logic v, input logic e, input logic [31:0] d);
        mem_bus.rsp_valid = v; mem_bus.rsp_err = e; mem_bus.rsp_rdata = d;
    endtask

    task automatic clear_model();
        for (int m = 0; m < 3; m++) begin
            pend[m] = 1'b0; p_addr[m] = '0; p_read[m] = 1'b0; p_wdata[m] = '0; p_wmask[m] = '0;
        end
        last_srv = LSU;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        apply_masters();
        set_mem_rsp(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rspv", 64'(rspv_vec()), 64'd0);
        chk("rst_svalid", 64'(mem_bus.cmd_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Accepts one request at the current cycle, answers after `lat` cycles
    // (lat==0: never), and returns at the cycle after the response.
    task automatic run_txn(input int lat, input logic e, input logic [31:0] d, output int w);
        logic [2:0] exp_v;
        logic       exp_e;
        logic       done;
        apply_masters();
        #2;
        w = exp_winner();
        chk("acc_busy", 64'(busy), 64'd0);
        chk("acc_ready", 64'(ready_vec()), 64'(3'b001 << w));
        chk("acc_svalid", 64'(mem_bus.cmd_valid), 64'd1);
        chk("acc_addr", 64'(mem_bus.cmd_addr), 64'(p_addr[w]));
        chk("acc_read", 64'(mem_bus.cmd_read), 64'(p_read[w]));
        chk("acc_wdata", 64'(mem_bus.cmd_wdata), 64'(p_wdata[w]));
        chk("acc_wmask", 64'(mem_bus.cmd_wmask), 64'(p_wmask[w]));
        $display("txn: master %0d accepted addr %h lat %0d", w, p_addr[w], lat);
        if (w != EXT) last_srv = w;
        pend[w] = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            #1;
            apply_masters();
            set_mem_rsp(k == lat, e, d);
            #2;
            done  = (k == lat) || (k == TMO);
            exp_e = (k == lat) ? e : 1'b1;
            exp_v = done ? (3'b001 << w) : 3'b000;
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_ready", 64'(ready_vec()), 64'd0);
            chk("wait_svalid", 64'(mem_bus.cmd_valid), 64'd0);
            chk("rsp_valid", 64'(rspv_vec()), 64'(exp_v));
            chk("rsp_err", 64'(err_vec()), 64'(exp_v & {3{exp_e}}));
            for (int m = 0; m < 3; m++)
                chk("rsp_rdata", 64'(rdata_of(m)),
                    64'((done && m == w && k == lat) ? d : 32'd0));
            if (done) break;
        end
        @(posedge clk);
        #1;
        set_mem_rsp(1'b0, 1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int seq [4];
        mem_bus.cmd_ready = 1'b0;
        rst_n = 1'b0;
        do_reset();

        // Single IFU read returning 0xDEADBEEF one cycle later.
        set_req(IFU, 32'h100, 1'b1, 32'h0, 4'h0);
        run_txn(1, 1'b0, 32'hDEADBEEF, w);
        chk("single_winner", 64'(w), 64'(IFU));

        // IFU and LSU continuously requesting alternate from a fresh reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!pend[IFU]) set_req(IFU, 32'h200 + 32'(i), 1'b1, 32'h0, 4'h0);
            if (!pend[LSU]) set_req(LSU, 32'h300 + 32'(i), 1'b1, 32'h0, 4'h0);
            run_txn(1, 1'b0, 32'hA000 + 32'(i), w);
            seq[i] = w;
        end
        chk("rr_0", 64'(seq[0]), 64'(IFU));
        chk("rr_1", 64'(seq[1]), 64'(LSU));
        chk("rr_2", 64'(seq[2]), 64'(IFU));
        chk("rr_3", 64'(seq[3]), 64'(LSU));
        set_req(IFU, 32'h210, 1'b1, 32'h0, 4'h0);
        set_req(LSU, 32'h310, 1'b1, 32'h0, 4'h0);
        set_req(EXT, 32'h400, 1'b1, 32'h0, 4'h0);
        run_txn(2, 1'b0, 32'h5555, w);
        chk("ext_prio", 64'(w), 64'(EXT));
        run_txn(1, 1'b0, 32'h1, w);
        run_txn(1, 1'b0, 32'h2, w);

        // No response: error at N+TMO, late response at N+18 dropped.
        set_req(LSU, 32'h500, 1'b1, 32'h0, 4'h0);
        run_txn(0, 1'b0, 32'h0, w);
        apply_masters();
        @(posedge clk);
        #1;
        set_mem_rsp(1'b1, 1'b0, 32'hBAD0BAD0);
        #2;
        chk("late_rspv", 64'(rspv_vec()), 64'd0);
        chk("late_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        set_mem_rsp(1'b0, 1'b0, '0);

        // Response lands exactly on the timeout cycle: slave wins.
        set_req(IFU, 32'h600, 1'b1, 32'h0, 4'h0);
        run_txn(TMO, 1'b1, 32'hC0FFEE00, w);
        #2;
        chk("coinc_no_extra", 64'(rspv_vec()), 64'd0);
        chk("coinc_idle", 64'(busy), 64'd0);

        // LSU write: payload seen once, read=0.
        set_req(LSU, 32'h700, 1'b0, 32'h12345678, 4'hF);
        run_txn(1, 1'b0, 32'h0, w);

        // Reset while waiting: transaction abandoned, late response dropped.
        set_req(IFU, 32'h800, 1'b1, 32'h0, 4'h0);
        apply_masters();
        #2;
        chk("rw_acc", 64'(ready_vec()), 64'(3'b010));
        pend[IFU] = 1'b0;
        @(posedge clk);
        #1;
        apply_masters();
        rst_n = 1'b0;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_rspv", 64'(rspv_vec()), 64'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_mem_rsp(1'b1, 1'b0, 32'h77777777);
        #2;
        chk("rw_late", 64'(rspv_vec()), 64'd0);
        @(posedge clk);
        #1;
        set_mem_rsp(1'b0, 1'b0, '0);
        set_req(LSU, 32'h900, 1'b1, 32'h0, 4'h0);
        run_txn(2, 1'b0, 32'h99, w);
        chk("rw_next", 64'(w), 64'(LSU));

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            int r;
            int lat;
            for (int m = 0; m < 3; m++) begin
                if (!pend[m] && ($urandom_range(0, 2) == 0))
                    set_req(m, $urandom, 1'($urandom), $urandom, 4'($urandom));
            end
            if (exp_winner() < 0) begin
                apply_masters();
                #2;
                chk("idle_ready", 64'(ready_vec()), 64'd0);
                chk("idle_svalid", 64'(mem_bus.cmd_valid), 64'd0);
                chk("idle_saddr", 64'(mem_bus.cmd_addr), 64'd0);
                @(posedge clk);
                #1;
                continue;
            end
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : ((r == 1) ? TMO : $urandom_range(1, 4));
            run_txn(lat, 1'($urandom), $urandom, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
